// File: rtl/mrd_bank_rd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mrd_bank_rd_sched : maps per-lane linear addresses onto NBANK RAM banks,   |
// | issues bank reads and returns per-lane read data RD_LAT cycles later.      |
// | Optional build macro: MRD_RD_CONFLICT_CHK_EN (sticky bank-conflict flag).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mrd_bank_rd_sched #(
  parameter int NBANK  = 7,
  parameter int NLANE  = 5,
  parameter int wADDR  = 9,
  parameter int wLIN   = 12,
  parameter int wDATA  = 30,
  parameter int RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [wLIN-1:0]          len,
  input  logic [3:0]               nact,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [NLANE*wLIN-1:0]    req_addr,
  output logic [NBANK-1:0]         bank_rden,
  output logic [NBANK*wADDR-1:0]   bank_rdaddr,
  input  logic [NBANK*wDATA-1:0]   bank_dout_re,
  input  logic [NBANK*wDATA-1:0]   bank_dout_im,
  output logic                     out_valid,
  output logic [NLANE*wDATA-1:0]   out_re,
  output logic [NLANE*wDATA-1:0]   out_im,
  output logic [NLANE*4-1:0]       out_bidx,
  output logic [NLANE*wADDR-1:0]   out_baddr,
  output logic                     busy,
  output logic                     done,
  output logic                     conflict
);

  localparam logic [1:0]      c_idle   = 2'd0;
  localparam logic [1:0]      c_run    = 2'd1;
  localparam logic [1:0]      c_drain  = 2'd2;
  localparam logic [3:0]      c_inv    = 4'(NBANK);
  localparam logic [3:0]      c_nlane  = 4'(NLANE);
  localparam logic [wLIN-1:0] c_nb_lin = wLIN'(NBANK);

  logic [1:0]              r_state, w_state_nxt;
  logic [wLIN-1:0]         r_len, r_cnt;
  logic [3:0]              r_nact, w_nact_clamp;
  logic                    r_zero_done;
  logic                    w_start_ok, w_accept, w_last, w_pipe_empty;

  logic [wLIN-1:0]         w_lane_addr;
  logic [NLANE*4-1:0]      w_s1_bidx, r_s1_bidx;
  logic [NLANE*wADDR-1:0]  w_s1_baddr, r_s1_baddr;
  logic                    r_s1_valid;

  logic [NBANK-1:0]        w_rden;
  logic [NBANK*wADDR-1:0]  w_rdaddr;
  // Index 0 is S2 (aligned with bank_rden), index RD_LAT aligns with bank_dout.
  logic [RD_LAT:0]         r_dv;
  logic [NLANE*4-1:0]      r_db [0:RD_LAT];
  logic [NLANE*wADDR-1:0]  r_da [0:RD_LAT];

  assign w_start_ok   = start && (r_state == c_idle);
  assign w_accept     = req_valid && req_ready;
  assign w_last       = (r_cnt == r_len - 1'b1);
  assign w_pipe_empty = !r_s1_valid && (r_dv == '0);
  assign w_nact_clamp = (nact == 4'd0) ? 4'd1 : ((nact > c_nlane) ? c_nlane : nact);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (start && (len != '0)) w_state_nxt = c_run;
      c_run:   if (w_accept && w_last)   w_state_nxt = c_drain;
      c_drain: if (w_pipe_empty)         w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    req_ready = (r_state == c_run);
    busy      = (r_state != c_idle);
    done      = r_zero_done || ((r_state == c_drain) && w_pipe_empty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_cnt       <= '0;
      r_nact      <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= w_start_ok && (len == '0);
      if (w_start_ok && (len != '0)) begin
        r_len  <= len;
        r_nact <= w_nact_clamp;
        r_cnt  <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_s1_bidx   = '0;
    w_s1_baddr  = '0;
    w_lane_addr = '0;
    for (int k = 0; k < NLANE; k++) begin
      w_lane_addr = req_addr[k*wLIN +: wLIN];
      if (k < int'(r_nact)) begin
        w_s1_bidx[k*4 +: 4]          = 4'(w_lane_addr % c_nb_lin);
        w_s1_baddr[k*wADDR +: wADDR] = wADDR'(w_lane_addr / c_nb_lin);
      end else begin
        w_s1_bidx[k*4 +: 4] = c_inv;
      end
    end
  end

  // Walk lanes high to low so the lowest lane claiming a bank wins.
  always_comb begin
    w_rden   = '0;
    w_rdaddr = '0;
    for (int k = NLANE - 1; k >= 0; k--) begin
      for (int b = 0; b < NBANK; b++) begin
        if (r_s1_valid && (r_s1_bidx[k*4 +: 4] == 4'(b))) begin
          w_rden[b]                   = 1'b1;
          w_rdaddr[b*wADDR +: wADDR]  = r_s1_baddr[k*wADDR +: wADDR];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_bidx   <= '0;
      r_s1_baddr  <= '0;
      bank_rden   <= '0;
      bank_rdaddr <= '0;
      r_dv        <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        r_db[i] <= '0;
        r_da[i] <= '0;
      end
    end else begin
      r_s1_valid  <= w_accept;
      r_s1_bidx   <= w_s1_bidx;
      r_s1_baddr  <= w_s1_baddr;
      bank_rden   <= w_rden;
      bank_rdaddr <= w_rdaddr;
      r_dv[0]     <= r_s1_valid;
      r_db[0]     <= r_s1_bidx;
      r_da[0]     <= r_s1_baddr;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_dv[i] <= r_dv[i-1];
        r_db[i] <= r_db[i-1];
        r_da[i] <= r_da[i-1];
      end
    end
  end

  always_comb begin
    out_valid = r_dv[RD_LAT];
    out_bidx  = '0;
    out_baddr = '0;
    out_re    = '0;
    out_im    = '0;
    if (r_dv[RD_LAT]) begin
      out_bidx  = r_db[RD_LAT];
      out_baddr = r_da[RD_LAT];
      for (int k = 0; k < NLANE; k++) begin
        for (int b = 0; b < NBANK; b++) begin
          if (r_db[RD_LAT][k*4 +: 4] == 4'(b)) begin
            out_re[k*wDATA +: wDATA] = bank_dout_re[b*wDATA +: wDATA];
            out_im[k*wDATA +: wDATA] = bank_dout_im[b*wDATA +: wDATA];
          end
        end
      end
    end
  end

`ifdef MRD_RD_CONFLICT_CHK_EN
  logic w_conf;
  logic r_conflict;

  always_comb begin
    w_conf = 1'b0;
    for (int j = 0; j < NLANE; j++) begin
      for (int k = j + 1; k < NLANE; k++) begin
        if (r_s1_valid && (r_s1_bidx[j*4 +: 4] != c_inv) &&
            (r_s1_bidx[j*4 +: 4] == r_s1_bidx[k*4 +: 4]))
          w_conf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)          r_conflict <= 1'b0;
    else if (w_start_ok) r_conflict <= 1'b0;
    else if (w_conf)     r_conflict <= 1'b1;
  end

  assign conflict = r_conflict;
`else
  assign conflict = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mrd_bank_rd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mrd_bank_rd_sched : directed self-checking bench with a behavioural     |
// | banked RAM; a second instance covers the NBANK=5 / RD_LAT=1 build.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mrd_bank_rd_sched;

  localparam int NB0 = 7;
  localparam int NB1 = 5;
  localparam int NL  = 5;
  localparam int WA  = 9;
  localparam int WL  = 12;
  localparam int WD  = 30;
`ifdef MRD_RD_CONFLICT_CHK_EN
  localparam logic c_exp_conf = 1'b1;
`else
  localparam logic c_exp_conf = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 start, req_valid, req_ready, out_valid, busy, done, conflict;
  logic [WL-1:0]        len;
  logic [3:0]           nact;
  logic [NL*WL-1:0]     req_addr;
  logic [NB0-1:0]       bank_rden;
  logic [NB0*WA-1:0]    bank_rdaddr, a0_q1, a0_q2;
  logic [NB0*WD-1:0]    dout_re, dout_im;
  logic [NL*WD-1:0]     out_re, out_im;
  logic [NL*4-1:0]      out_bidx;
  logic [NL*WA-1:0]     out_baddr;

  logic                 start_b, req_valid_b, req_ready_b, out_valid_b, busy_b, done_b, conflict_b;
  logic [WL-1:0]        len_b;
  logic [3:0]           nact_b;
  logic [NL*WL-1:0]     req_addr_b;
  logic [NB1-1:0]       bank_rden_b;
  logic [NB1*WA-1:0]    bank_rdaddr_b, a1_q1;
  logic [NB1*WD-1:0]    dout_re_b, dout_im_b;
  logic [NL*WD-1:0]     out_re_b, out_im_b;
  logic [NL*4-1:0]      out_bidx_b;
  logic [NL*WA-1:0]     out_baddr_b;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int d0;

  mrd_bank_rd_sched u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .nact(nact),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .bank_rden(bank_rden), .bank_rdaddr(bank_rdaddr),
    .bank_dout_re(dout_re), .bank_dout_im(dout_im),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
    .out_bidx(out_bidx), .out_baddr(out_baddr),
    .busy(busy), .done(done), .conflict(conflict)
  );

  mrd_bank_rd_sched #(.NBANK(NB1), .RD_LAT(1)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .len(len_b), .nact(nact_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b),
    .bank_rden(bank_rden_b), .bank_rdaddr(bank_rdaddr_b),
    .bank_dout_re(dout_re_b), .bank_dout_im(dout_im_b),
    .out_valid(out_valid_b), .out_re(out_re_b), .out_im(out_im_b),
    .out_bidx(out_bidx_b), .out_baddr(out_baddr_b),
    .busy(busy_b), .done(done_b), .conflict(conflict_b)
  );

  function automatic logic [WD-1:0] f_re(int b, int a);
    return WD'(b * 4096 + a + 1);
  endfunction

  function automatic logic [WD-1:0] f_im(int b, int a);
    return WD'(32'h0010_0000 + b * 4096 + a);
  endfunction

  // Banked RAM model: read address pipelined RD_LAT cycles, content a fixed function.
  always @(posedge clk) begin
    a0_q1 <= bank_rdaddr;
    a0_q2 <= a0_q1;
    a1_q1 <= bank_rdaddr_b;
    if (done) n_done++;
  end

  always_comb begin
    for (int b = 0; b < NB0; b++) begin
      dout_re[b*WD +: WD] = f_re(b, int'(a0_q2[b*WA +: WA]));
      dout_im[b*WD +: WD] = f_im(b, int'(a0_q2[b*WA +: WA]));
    end
    for (int b = 0; b < NB1; b++) begin
      dout_re_b[b*WD +: WD] = f_re(b, int'(a1_q1[b*WA +: WA]));
      dout_im_b[b*WD +: WD] = f_im(b, int'(a1_q1[b*WA +: WA]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic begin_burst(input int l, input int na);
    start = 1'b1;
    len   = WL'(l);
    nact  = 4'(na);
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; nact = '0; req_valid = 1'b0; req_addr = '0;
    start_b = 1'b0; len_b = '0; nact_b = '0; req_valid_b = 1'b0; req_addr_b = '0;
    repeat (3) tick();
    chk_val("rst_ready", req_ready, 0);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_done", done, 0);
    chk_val("rst_rden", bank_rden, 0);
    chk_val("rst_conf", conflict, 0);
    rst_n = 1'b1;
    tick();

    // Single vector, five lanes onto five distinct banks.
    d0 = n_done;
    begin_burst(1, 5);
    chk_val("run_ready", req_ready, 1);
    req_valid = 1'b1;
    for (int k = 0; k < NL; k++) req_addr[k*WL +: WL] = WL'(k);
    tick();
    req_valid = 1'b0;
    chk_val("drain_ready", req_ready, 0);
    tick();
    chk_val("s2_rden", bank_rden, 7'h1F);
    chk_val("s2_rdaddr", bank_rdaddr, 0);
    tick();
    chk_val("a3_valid", out_valid, 0);
    tick();
    chk_val("a4_valid", out_valid, 1);
    chk_val("a4_bidx", out_bidx, 20'h43210);
    chk_val("a4_re2", out_re[2*WD +: WD], f_re(2, 0));
    chk_val("a4_done", done, 0);
    tick();
    chk_val("a5_done", done, 1);
    chk_val("a5_valid", out_valid, 0);
    tick();
    chk_val("idle_busy", busy, 0);
    chk_val("done_once", n_done - d0, 1);

    // Two active lanes colliding in bank 1; invalid lanes point at bank 1 too.
    begin_burst(1, 2);
    req_valid = 1'b1;
    req_addr = '0;
    req_addr[0*WL +: WL] = 12'd15;
    req_addr[1*WL +: WL] = 12'd22;
    for (int k = 2; k < NL; k++) req_addr[k*WL +: WL] = 12'd1;
    tick();
    req_valid = 1'b0;
    tick();
    chk_val("cf_rden", bank_rden, 7'b0000010);
    chk_val("cf_rdaddr", bank_rdaddr, 64'h400);
    chk_val("cf_conflict", conflict, c_exp_conf);
    repeat (2) tick();
    chk_val("cf_valid", out_valid, 1);
    chk_val("cf_bidx", out_bidx, 20'h77711);
    chk_val("cf_baddr", out_baddr[2*WA-1:0], 18'h602);
    chk_val("cf_re0", out_re[0 +: WD], f_re(1, 2));
    chk_val("cf_re1", out_re[WD +: WD], f_re(1, 2));
    chk_val("cf_im0", out_im[0 +: WD], f_im(1, 2));
    chk_val("cf_inv_re", |out_re[NL*WD-1:2*WD], 0);
    repeat (2) tick();

    // Zero-length burst: done next cycle, never busy; clears a sticky conflict.
    d0 = n_done;
    start = 1'b1; len = '0; nact = 4'd5;
    chk_val("z_busy0", busy, 0);
    tick();
    start = 1'b0;
    chk_val("z_done", done, 1);
    chk_val("z_busy1", busy, 0);
    chk_val("z_conf_clr", conflict, 0);
    tick();
    chk_val("z_done_off", done, 0);
    chk_val("z_done_cnt", n_done - d0, 1);

    // Eight back-to-back vectors; lane 0 hits bank 3 at bank address c.
    begin_burst(8, 5);
    for (int c = 0; c < 15; c++) begin
      req_valid = (c < 8);
      for (int k = 0; k < NL; k++) req_addr[k*WL +: WL] = WL'(c * 7 + 3 + k);
      chk_val($sformatf("bb_ready_%0d", c), req_ready, (c < 8));
      chk_val($sformatf("bb_valid_%0d", c), out_valid, (c >= 4 && c < 12));
      chk_val($sformatf("bb_done_%0d", c), done, (c == 12));
      if (c >= 4 && c < 12) begin
        chk_val($sformatf("bb_baddr_%0d", c), out_baddr[0 +: WA], c - 4);
        chk_val($sformatf("bb_re_%0d", c), out_re[0 +: WD], f_re(3, c - 4));
      end
      tick();
    end

    // Reset after three acceptances aborts the burst silently.
    begin_burst(8, 5);
    req_valid = 1'b1;
    repeat (3) tick();
    d0 = n_done;
    rst_n = 1'b0;
    req_valid = 1'b0;
    tick();
    chk_val("ab_ready", req_ready, 0);
    chk_val("ab_busy", busy, 0);
    chk_val("ab_done", done, 0);
    chk_val("ab_rden", bank_rden, 0);
    chk_val("ab_rdaddr", bank_rdaddr, 0);
    chk_val("ab_valid", out_valid, 0);
    chk_val("ab_re", |out_re, 0);
    chk_val("ab_bidx", out_bidx, 0);
    chk_val("ab_conf", conflict, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_val("ab_no_done", n_done - d0, 0);
    begin_burst(1, 1);
    req_valid = 1'b1;
    req_addr[0 +: WL] = 12'd13;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    chk_val("rs_valid", out_valid, 1);
    chk_val("rs_bidx", out_bidx, 20'h77776);
    chk_val("rs_re0", out_re[0 +: WD], f_re(6, 1));
    tick();
    chk_val("rs_done", done, 1);
    tick();

    // NBANK=5, RD_LAT=1 instance.
    start_b = 1'b1; len_b = 12'd1; nact_b = 4'd1;
    tick();
    start_b = 1'b0;
    req_valid_b = 1'b1;
    req_addr_b[0 +: WL] = 12'd13;
    tick();
    req_valid_b = 1'b0;
    chk_val("b5_a1_valid", out_valid_b, 0);
    tick();
    chk_val("b5_rden", bank_rden_b, 5'b01000);
    chk_val("b5_rdaddr", bank_rdaddr_b, 64'h1000_0000);
    chk_val("b5_a2_valid", out_valid_b, 0);
    tick();
    chk_val("b5_a3_valid", out_valid_b, 1);
    chk_val("b5_bidx", out_bidx_b[3:0], 3);
    chk_val("b5_re0", out_re_b[0 +: WD], f_re(3, 2));
    tick();
    chk_val("b5_done", done_b, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mrd_bank_rd_sched.md
MRD_BANK_RD_SCHED -- requirements
Module: mrd_bank_rd_sched

Interface
REQ-001 SHALL have parameter NBANK, default 7, number of RAM banks (2..15).
REQ-002 SHALL have parameter NLANE, default 5, number of butterfly lanes (1..8).
REQ-003 SHALL have parameter wADDR, default 9, per-bank address width.
REQ-004 SHALL have parameter wLIN, default 12, linear address width.
REQ-005 SHALL have parameter wDATA, default 30, per-component sample width.
REQ-006 SHALL have parameter RD_LAT, default 2, RAM read latency in cycles (1..4).
REQ-007 SHALL have ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle burst start pulse
- len  in  wLIN  butterflies in the burst, sampled on start
- nact  in  4  active lanes, sampled on start
- req_valid  in  1  lane address vector valid
- req_ready  out  1  scheduler accepts the vector
- req_addr  in  NLANE*wLIN  linear address per lane
- bank_rden  out  NBANK  per-bank read enable
- bank_rdaddr  out  NBANK*wADDR  per-bank read address
- bank_dout_re, bank_dout_im  in  NBANK*wDATA  per-bank read data
- out_valid  out  1  lane data valid
- out_re, out_im  out  NLANE*wDATA  lane data
- out_bidx  out  NLANE*4  bank index per lane; NBANK marks an invalid lane
- out_baddr  out  NLANE*wADDR  bank address per lane
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle burst-complete pulse
- conflict  out  1  sticky bank-conflict flag

Function
REQ-008 SHALL implement the FSM IDLE, RUN, DRAIN.
REQ-009 IDLE: start with len!=0 SHALL latch len and nact (nact clamped to 1..NLANE) and enter RUN; start with len==0 SHALL pulse done on the next cycle and remain in IDLE.
REQ-010 start while not IDLE SHALL be ignored.
REQ-011 req_ready SHALL be 1 only in RUN.
REQ-012 Each req_valid&&req_ready SHALL increment the accept count; acceptance of the len-th vector SHALL move the FSM to DRAIN.
REQ-013 DRAIN SHALL leave to IDLE, pulsing done in the same cycle, when no accepted vector remains in the pipeline.
REQ-014 Per lane k, the bank index SHALL be addr mod NBANK and the bank address SHALL be addr div NBANK, truncated to wADDR, registered one cycle after acceptance (stage S1).
REQ-015 Lanes k>=nact SHALL get index NBANK (invalid) and SHALL NOT enable any bank.
REQ-016 At S2 (two cycles after acceptance), bank b SHALL register bank_rden[b]=1 and bank_rdaddr[b] equal to the bank address of the lowest valid lane with index b; banks with no lane SHALL register rden=0 and rdaddr=0.
REQ-017 out_valid SHALL assert exactly 2+RD_LAT cycles after acceptance.
REQ-018 out_re[k]/out_im[k] SHALL equal bank_dout of the lane's delayed index, and 0 for invalid lanes.
REQ-019 out_bidx and out_baddr SHALL be delayed alongside the data.
REQ-020 Back-to-back acceptances SHALL sustain one vector per cycle with no bubbles.

Reset
REQ-021 rst_n low SHALL force state IDLE, counters 0, pipeline valids 0, and all outputs 0 (req_ready, bank_rden, bank_rdaddr, out_*, busy, done, conflict), aborting any burst in progress, with no done pulse.
REQ-022 Out of reset, the first start SHALL behave identically to start after a completed burst.

Configuration
REQ-023 With macro MRD_RD_CONFLICT_CHK_EN defined, two valid lanes in one vector sharing a bank index SHALL set conflict at S2; conflict SHALL clear only on reset or on start accepted in IDLE.
REQ-024 Without the macro, conflict SHALL be tied to 0 and no conflict logic SHALL exist; lowest-lane-wins arbitration (REQ-016) SHALL apply in both builds.

Verification
REQ-025 Defaults; start, len=1, nact=5, addrs {0,1,2,3,4} -> rden=0x1F at S2, out_valid at acceptance+4, out_bidx {0,1,2,3,4}, done once.
REQ-026 nact=2, addrs {15,22,x,x,x} -> banks 1 (rdaddr 2) and 1? No: 15->bank1/addr2, 22->bank1/addr3; with macro, conflict=1, bank1 rdaddr=2; lanes 2-4 bidx=7, data 0.
REQ-027 len=8, req_valid held 1 -> 8 consecutive out_valid cycles, done one cycle after the last.
REQ-028 start with len=0 -> done next cycle, busy never 1.
REQ-029 rst_n low mid-burst after 3 acceptances -> next cycle: all outputs 0, state IDLE, no done; a new start then works.
REQ-030 RD_LAT=1, NBANK=5 build, addr 13 lane0 -> bank3, rdaddr 2, out_valid at acceptance+3.
